// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core control path: opcode constants,
// the hazard-unit state encoding and a small opcode helper.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_t;

    // Only R-type, store and branch read a second source register.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts clock edges where i_inc is high, sticks at
// all-ones, cleared by an asynchronous active-low reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    // Count up on each enabled edge until the counter is full.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller in ID: load-use stall, taken-branch flush and the ecall
// drain/halt sequence. Optional performance counters are built only when the
// macro HAZARD_PERF_CNT_EN is defined; otherwise their ports are tied to 0.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [6:0]       IFID_opcode_i,
    input  logic [4:0]       IFID_RS1_i,
    input  logic [4:0]       IFID_RS2_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RD_i,
    input  logic             Branch_taken_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             NoOP_o,
    output logic             Flush_o,
    output logic             Halt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    hz_state_t  r_state;
    hz_state_t  w_state_nxt;
    logic [3:0] r_drain_cnt;
    logic [3:0] w_drain_cnt_nxt;
    logic       r_halt;
    logic       w_lu;
    logic       w_ecall;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    always_comb begin
        w_lu = IDEX_MemRead_i && (IDEX_RD_i != 5'd0) &&
               ((IDEX_RD_i == IFID_RS1_i) ||
                (uses_rs2(IFID_opcode_i) && (IDEX_RD_i == IFID_RS2_i)));
    end

    // ecall only takes effect when neither a stall nor a flush has priority.
    assign w_ecall = !w_lu && !Branch_taken_i && (IFID_opcode_i == OP_ECALL);

    // State and drain-counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= RUN;
            r_drain_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    // Next-state logic: RUN -> DRAIN on ecall, DRAIN counts down to HALTED.
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            RUN: begin
                if (w_ecall) begin
                    w_state_nxt     = DRAIN;
                    w_drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == 4'd0) begin
                    w_state_nxt = HALTED;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - 4'd1;
                end
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            default: begin
                w_state_nxt     = RUN;
                w_drain_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Combinational pipeline steering; reset holds the pipe frozen with a bubble.
    always_comb begin
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
        NoOP_o      = 1'b0;
        Flush_o     = 1'b0;
        if (!rst_n_i) begin
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            NoOP_o      = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_lu || w_ecall) begin
                        // Stall: freeze PC and IF/ID, bubble into EX (ecall enters EX as a bubble).
                        PCWrite_o   = 1'b0;
                        IFIDWrite_o = 1'b0;
                        NoOP_o      = 1'b1;
                    end else if (Branch_taken_i) begin
                        Flush_o = 1'b1;
                    end
                end
                default: begin
                    // DRAIN and HALTED: fetch stopped, only bubbles issued.
                    PCWrite_o   = 1'b0;
                    IFIDWrite_o = 1'b0;
                    NoOP_o      = 1'b1;
                end
            endcase
        end
    end

    // Sticky halt flag, registered one edge after HALTED is entered.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_halt <= 1'b0;
        end else if (r_state == HALTED) begin
            r_halt <= 1'b1;
        end
    end

    assign Halt_o = r_halt;

`ifdef HAZARD_PERF_CNT_EN
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = (r_state == RUN) && w_lu;
    assign w_flush_inc = Flush_o;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (w_stall_inc),
        .cnt_o   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (w_flush_inc),
        .cnt_o   (flush_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vectors with literal expectations plus a
// behavioural model compared against the outputs on every falling edge.
module tb_hazard_unit;

    localparam int D  = 3;
    localparam int CW = 4;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] ST_OP = 7'b0100011;
    localparam logic [6:0] BR_OP = 7'b1100011;
    localparam logic [6:0] EC_OP = 7'b1110011;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    opcode;
    logic [4:0]    rs1, rs2, rd;
    logic          mr, br;
    logic          pcw, ifidw, noop, flush, halt;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    hazard_unit #(.DRAIN_CYCLES(D), .CNT_W(CW)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .IFID_opcode_i  (opcode),
        .IFID_RS1_i     (rs1),
        .IFID_RS2_i     (rs2),
        .IDEX_MemRead_i (mr),
        .IDEX_RD_i      (rd),
        .Branch_taken_i (br),
        .PCWrite_o      (pcw),
        .IFIDWrite_o    (ifidw),
        .NoOP_o         (noop),
        .Flush_o        (flush),
        .Halt_o         (halt),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_lu();
        bit u;
        u = (opcode == R_OP) || (opcode == ST_OP) || (opcode == BR_OP);
        return mr && (rd != 0) && ((rd == rs1) || (u && (rd == rs2)));
    endfunction

    int m_edge;        // edges since reset release
    int m_ecall_edge;  // edge at which ecall was accepted, -1 if none
    int m_stall;
    int m_flush;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edge       <= 0;
            m_ecall_edge <= -1;
            m_stall      <= 0;
            m_flush      <= 0;
        end else begin
            m_edge <= m_edge + 1;
            if (m_ecall_edge < 0) begin
                if (m_lu())
                    m_stall <= (m_stall < 15) ? m_stall + 1 : 15;
                else if (br)
                    m_flush <= (m_flush < 15) ? m_flush + 1 : 15;
                else if (opcode == EC_OP)
                    m_ecall_edge <= m_edge + 1;
            end
        end
    end

    always @(negedge clk) begin
        bit e_pc, e_ifid, e_noop, e_flush, e_halt;
        int k;
        e_pc = 1; e_ifid = 1; e_noop = 0; e_flush = 0; e_halt = 0;
        if (!rst_n) begin
            e_pc = 0; e_ifid = 0; e_noop = 1;
        end else if (m_ecall_edge >= 0) begin
            k = m_edge - m_ecall_edge;
            e_pc = 0; e_ifid = 0; e_noop = 1;
            e_halt = (k >= D + 1);
        end else if (m_lu() || (!br && opcode == EC_OP)) begin
            e_pc = 0; e_ifid = 0; e_noop = 1;
        end else if (br) begin
            e_flush = 1;
        end
        chk("model_PCWrite", 32'(pcw), 32'(e_pc));
        chk("model_IFIDWrite", 32'(ifidw), 32'(e_ifid));
        chk("model_NoOP", 32'(noop), 32'(e_noop));
        chk("model_Flush", 32'(flush), 32'(e_flush));
        chk("model_Halt", 32'(halt), 32'(e_halt));
`ifdef HAZARD_PERF_CNT_EN
        chk("model_stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("model_flush_cnt", 32'(flush_cnt), 32'(m_flush));
`else
        chk("model_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("model_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic m, input logic [4:0] d, input logic b);
        opcode = op; rs1 = r1; rs2 = r2; mr = m; rd = d; br = b;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(R_OP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("rst_PCWrite", 32'(pcw), 32'd0);
        chk("rst_IFIDWrite", 32'(ifidw), 32'd0);
        chk("rst_NoOP", 32'(noop), 32'd1);
        chk("rst_Flush", 32'(flush), 32'd0);
        chk("rst_Halt", 32'(halt), 32'd0);
        next();
        rst_n = 1'b1;

        @(negedge clk);
        chk("run_default_PCWrite", 32'(pcw), 32'd1);

        // load-use on rs1
        next(); drive(R_OP, 5'd5, 5'd6, 1'b1, 5'd5, 1'b0);
        @(negedge clk);
        chk("lu_rs1_PCWrite", 32'(pcw), 32'd0);
        chk("lu_rs1_IFIDWrite", 32'(ifidw), 32'd0);
        chk("lu_rs1_NoOP", 32'(noop), 32'd1);
        next(); drive(R_OP, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("lu_rs1_release_PCWrite", 32'(pcw), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
        chk("lu_rs1_stall_cnt", 32'(stall_cnt), 32'd1);
`endif

        // I-type does not read rs2
        next(); drive(I_OP, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0);
        @(negedge clk);
        chk("itype_rs2_PCWrite", 32'(pcw), 32'd1);

        // x0 never hazards
        next(); drive(R_OP, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        chk("x0_PCWrite", 32'(pcw), 32'd1);
        chk("x0_NoOP", 32'(noop), 32'd0);

        // store reads rs2
        next(); drive(ST_OP, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0);
        @(negedge clk);
        chk("store_rs2_PCWrite", 32'(pcw), 32'd0);

        // stall wins over branch, then branch alone flushes
        next(); drive(BR_OP, 5'd3, 5'd4, 1'b1, 5'd3, 1'b1);
        @(negedge clk);
        chk("br_lu_Flush", 32'(flush), 32'd0);
        chk("br_lu_NoOP", 32'(noop), 32'd1);
        next(); drive(BR_OP, 5'd3, 5'd4, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        chk("br_Flush", 32'(flush), 32'd1);
        chk("br_PCWrite", 32'(pcw), 32'd1);
        next(); drive(R_OP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("br_Flush_one_cycle", 32'(flush), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd3);
`endif

        // saturation: 20 stalls on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            next(); drive(R_OP, 5'd8, 5'd9, 1'b1, 5'd8, 1'b0);
        end
        next(); drive(R_OP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
`else
        chk("off_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // ecall: drain then sticky halt
        next(); drive(EC_OP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("ecall_NoOP", 32'(noop), 32'd1);
        chk("ecall_PCWrite", 32'(pcw), 32'd0);
        next(); drive(R_OP, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_Halt", 32'(halt), 32'd0);
            chk("drain_NoOP", 32'(noop), 32'd1);
            chk("drain_Flush", 32'(flush), 32'd0);
            next();
        end
        @(negedge clk);
        chk("halt_rise", 32'(halt), 32'd1);
        for (int i = 0; i < 22; i++) begin
            next();
            @(negedge clk);
            chk("halt_hold", 32'(halt), 32'd1);
            chk("halt_PCWrite", 32'(pcw), 32'd0);
        end

        // reset in HALTED, then reset mid-drain
        next(); rst_n = 1'b0;
        #1;
        chk("rst_halted_Halt", 32'(halt), 32'd0);
        next(); rst_n = 1'b1; drive(R_OP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("post_rst_PCWrite", 32'(pcw), 32'd1);
        next(); drive(EC_OP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        next(); drive(R_OP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        next();
        @(negedge clk);
        chk("mid_drain_PCWrite", 32'(pcw), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_drain_PCWrite", 32'(pcw), 32'd0);
        chk("rst_drain_IFIDWrite", 32'(ifidw), 32'd0);
        chk("rst_drain_NoOP", 32'(noop), 32'd1);
        chk("rst_drain_Flush", 32'(flush), 32'd0);
        chk("rst_drain_Halt", 32'(halt), 32'd0);
        next(); rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_PCWrite", 32'(pcw), 32'd1);
        chk("after_rst_Halt", 32'(halt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            next();
            @(negedge clk);
            chk("after_rst_run_Halt", 32'(halt), 32'd0);
            chk("after_rst_run_PCWrite", 32'(pcw), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
